// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the UART reference clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_BYP   = 2'd3
   } state_e;

   // Length of the registered high phase (hi_pos) in clk cycles for ratio n.
   // Both modes round up; with odd50 the negedge AND stage trims the extra half clk.
   function automatic int unsigned half_ratio(input int unsigned n, input bit odd50);
      if (odd50) begin
         return (n + 1) >> 1;
      end
      return (n >> 1) + (n & 1);
   endfunction

endpackage

// File: rtl/clk_div_gen_clk_gate_cell.sv
// Glitch-free gate: enable retimed on the falling clk edge, then ANDed with the source.
module clk_gate_cell (
   input  logic clk,
   input  logic reset_n,
   input  logic en_in,
   input  logic src_in,
   output logic gate_on_out,
   output logic gated_c
);

   logic en_d;
   logic en_q;

   always_comb begin
      en_d = en_in;
   end

   // Enable only changes while clk is low, so a clk-sourced output never produces a runt.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q <= 1'b0;
      end else begin
         en_q <= en_d;
      end
   end

   assign gate_on_out = en_q;
   assign gated_c     = src_in & en_q;

endmodule

// File: rtl/clk_div_gen.sv
// Integer clock divider with period-aligned ratio updates, graceful stop and ratio 0/1 bypass.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter bit          ODD_50 = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clk_en_in,
   input  logic [WIDTH-1:0] div_ratio_in,
   output logic             div_clk_out,
   output logic             div_tick_out,
   output logic [WIDTH-1:0] ratio_active_out,
   output logic             running_out
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] ratio_q, ratio_d;
   logic             hi_pos_q, hi_pos_d;
   logic             tick_q, tick_d;
   logic             running_q, running_d;

   logic             req_ge2_c;
   logic             last_c;
   logic             start_c;
   logic             byp_req_c;
   logic [WIDTH-1:0] run_h_c;
   logic             byp_gate_on, odd_gate_on;
   logic             byp_clk_c, odd_clk_c;
   logic             odd_sel_c;

   assign req_ge2_c = (div_ratio_in >= WIDTH'(2));
   assign last_c    = (count_q == (ratio_q - WIDTH'(1)));
   assign run_h_c   = WIDTH'(half_ratio(32'(ratio_q), ODD_50));
   // Bypass gate is requested only while bypass is still wanted; it drops on the next falling edge.
   assign byp_req_c = (state_q == ST_BYP) && clk_en_in && !req_ge2_c;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ratio_d   = ratio_q;
      hi_pos_d  = 1'b0;
      tick_d    = 1'b0;
      start_c   = 1'b0;
      running_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ratio_d = div_ratio_in;
            count_d = '0;
            if (clk_en_in) begin
               if (req_ge2_c) begin
                  start_c = 1'b1;
               end else begin
                  state_d = ST_BYP;
               end
            end
         end
         ST_RUN, ST_DRAIN: begin
            hi_pos_d = (count_q < run_h_c);
            tick_d   = (count_q == '0);
            if (last_c) begin
               count_d = '0;
               ratio_d = div_ratio_in;
               if (!clk_en_in) begin
                  state_d = ST_IDLE;
               end else if (!req_ge2_c) begin
                  state_d = ST_BYP;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               count_d = count_q + WIDTH'(1);
               state_d = clk_en_in ? ST_RUN : ST_DRAIN;
            end
         end
         ST_BYP: begin
            ratio_d = div_ratio_in;
            count_d = '0;
            if (!clk_en_in) begin
               state_d = ST_IDLE;
            end else if (req_ge2_c && !byp_gate_on && !odd_gate_on) begin
               // Start dividing only once no gated path is still driving the output.
               start_c = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The starting edge processes count 0, so the first high phase begins immediately.
      if (start_c) begin
         state_d  = ST_RUN;
         count_d  = WIDTH'(1);
         hi_pos_d = 1'b1;
         tick_d   = 1'b1;
      end

      if (state_d == ST_BYP) begin
         tick_d = 1'b1;
      end
      running_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         ratio_q   <= '0;
         hi_pos_q  <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         ratio_q   <= ratio_d;
         hi_pos_q  <= hi_pos_d;
         tick_q    <= tick_d;
         running_q <= running_d;
      end
   end

   clk_gate_cell u_byp_gate (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_in       (byp_req_c),
      .src_in      (clk),
      .gate_on_out (byp_gate_on),
      .gated_c     (byp_clk_c)
   );

   // hi_pos ANDed with its own half-clk-late copy: delays the rise by half a clk for odd ratios.
   clk_gate_cell u_odd_gate (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_in       (hi_pos_q),
      .src_in      (hi_pos_q),
      .gate_on_out (odd_gate_on),
      .gated_c     (odd_clk_c)
   );

   assign odd_sel_c = ODD_50 && ratio_q[0];

   assign div_clk_out      = byp_clk_c | (odd_sel_c ? odd_clk_c : hi_pos_q);
   assign div_tick_out     = tick_q;
   assign ratio_active_out = ratio_q;
   assign running_out      = running_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen; one instance per ODD_50 setting share the stimulus.
module tb_clk_div_gen;

   logic       clk;
   logic       reset_n;
   logic       clk_en_in;
   logic [7:0] div_ratio_in;

   logic       div_clk_out, div_tick_out, running_out;
   logic [7:0] ratio_active_out;
   logic       div_clk0, tick0, running0;
   logic [7:0] ratio0;

   int n_tests;
   int n_fail;

   // Samples: p* at posedge+1, n* at negedge+1; suffix 0 is the ODD_50=0 instance
   logic sp, sn, st, sr, sp0, sn0;

   clk_div_gen #(.WIDTH(8), .ODD_50(1'b1)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .clk_en_in        (clk_en_in),
      .div_ratio_in     (div_ratio_in),
      .div_clk_out      (div_clk_out),
      .div_tick_out     (div_tick_out),
      .ratio_active_out (ratio_active_out),
      .running_out      (running_out)
   );

   clk_div_gen #(.WIDTH(8), .ODD_50(1'b0)) dut0 (
      .clk              (clk),
      .reset_n          (reset_n),
      .clk_en_in        (clk_en_in),
      .div_ratio_in     (div_ratio_in),
      .div_clk_out      (div_clk0),
      .div_tick_out     (tick0),
      .ratio_active_out (ratio0),
      .running_out      (running0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
      sp  = div_clk_out;
      st  = div_tick_out;
      sr  = running_out;
      sp0 = div_clk0;
      @(negedge clk);
      #1;
      sn  = div_clk_out;
      sn0 = div_clk0;
   endtask

   task automatic apply_reset();
      clk_en_in    = 1'b0;
      div_ratio_in = 8'd0;
      reset_n      = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      clk_en_in    = 1'b0;
      div_ratio_in = 8'd0;
      reset_n      = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({div_clk_out, div_tick_out, running_out, ratio_active_out} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {div_clk_out, div_tick_out, running_out, ratio_active_out}, 11'd0);
      end
      n_tests++;
      if ({div_clk0, tick0, running0, ratio0} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_odd50_off: got %b expected %b",
                  {div_clk0, tick0, running0, ratio0}, 11'd0);
      end
      repeat (2) @(negedge clk);
      #1;
      reset_n = 1'b1;
      cyc();
      n_tests++;
      if ({sp, sn, st, sr} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b expected %b", {sp, sn, st, sr}, 4'b0000);
      end
   endtask

   task automatic test_even_ratio();
      logic [15:0] pv, nv, tv, p0v;
      logic        all_run;
      apply_reset();
      div_ratio_in = 8'd4;
      clk_en_in    = 1'b1;
      pv = '0; nv = '0; tv = '0; p0v = '0; all_run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         pv  = {pv[14:0], sp};
         nv  = {nv[14:0], sn};
         tv  = {tv[14:0], st};
         p0v = {p0v[14:0], sp0};
         all_run = all_run & sr;
      end
      n_tests++;
      if (pv !== 16'b11001100) begin
         n_fail++; $display("FAIL n4_clk_pos: got %b expected %b", pv, 16'b11001100);
      end
      n_tests++;
      if (nv !== 16'b11001100) begin
         n_fail++; $display("FAIL n4_clk_neg: got %b expected %b", nv, 16'b11001100);
      end
      n_tests++;
      if (tv !== 16'b10001000) begin
         n_fail++; $display("FAIL n4_tick: got %b expected %b", tv, 16'b10001000);
      end
      n_tests++;
      if (p0v !== 16'b11001100) begin
         n_fail++; $display("FAIL n4_clk_odd50_off: got %b expected %b", p0v, 16'b11001100);
      end
      n_tests++;
      if (all_run !== 1'b1 || ratio_active_out !== 8'd4) begin
         n_fail++;
         $display("FAIL n4_running_ratio: got %b/%0d expected 1/4", all_run, ratio_active_out);
      end
   endtask

   task automatic test_min_ratio();
      logic [15:0] pv, tv, p0v;
      apply_reset();
      div_ratio_in = 8'd2;
      clk_en_in    = 1'b1;
      pv = '0; tv = '0; p0v = '0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         pv  = {pv[14:0], sp};
         tv  = {tv[14:0], st};
         p0v = {p0v[14:0], sp0};
      end
      n_tests++;
      if (pv !== 16'b101010 || p0v !== 16'b101010) begin
         n_fail++; $display("FAIL n2_clk: got %b/%b expected %b", pv, p0v, 16'b101010);
      end
      n_tests++;
      if (tv !== 16'b101010) begin
         n_fail++; $display("FAIL n2_tick: got %b expected %b", tv, 16'b101010);
      end
   endtask

   task automatic test_odd_ratio();
      logic [15:0] pv, nv, tv, p0v, n0v;
      apply_reset();
      div_ratio_in = 8'd5;
      clk_en_in    = 1'b1;
      pv = '0; nv = '0; tv = '0; p0v = '0; n0v = '0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         pv  = {pv[14:0], sp};
         nv  = {nv[14:0], sn};
         tv  = {tv[14:0], st};
         p0v = {p0v[14:0], sp0};
         n0v = {n0v[14:0], sn0};
      end
      n_tests++;
      if (pv !== 16'b0110001100) begin
         n_fail++; $display("FAIL n5_odd50_pos: got %b expected %b", pv, 16'b0110001100);
      end
      n_tests++;
      if (nv !== 16'b1110011100) begin
         n_fail++; $display("FAIL n5_odd50_neg: got %b expected %b", nv, 16'b1110011100);
      end
      n_tests++;
      if (tv !== 16'b1000010000) begin
         n_fail++; $display("FAIL n5_tick: got %b expected %b", tv, 16'b1000010000);
      end
      n_tests++;
      if (p0v !== 16'b1110011100 || n0v !== 16'b1110011100) begin
         n_fail++;
         $display("FAIL n5_odd50_off: got %b/%b expected %b", p0v, n0v, 16'b1110011100);
      end
   endtask

   task automatic test_ratio_change();
      logic [15:0] pv, tv, p0v;
      logic [7:0]  r2, r3;
      apply_reset();
      div_ratio_in = 8'd4;
      clk_en_in    = 1'b1;
      pv = '0; tv = '0; p0v = '0; r2 = '0; r3 = '0;
      for (int i = 0; i < 11; i++) begin
         cyc();
         if (i == 0) div_ratio_in = 8'd6;
         if (i == 2) r2 = ratio_active_out;
         if (i == 3) r3 = ratio_active_out;
         pv  = {pv[14:0], sp};
         tv  = {tv[14:0], st};
         p0v = {p0v[14:0], sp0};
      end
      n_tests++;
      if (pv !== 16'b11001110001 || p0v !== 16'b11001110001) begin
         n_fail++;
         $display("FAIL change_4_to_6_clk: got %b/%b expected %b", pv, p0v, 16'b11001110001);
      end
      n_tests++;
      if (tv !== 16'b10001000001) begin
         n_fail++; $display("FAIL change_4_to_6_tick: got %b expected %b", tv, 16'b10001000001);
      end
      n_tests++;
      if (r2 !== 8'd4 || r3 !== 8'd6) begin
         n_fail++; $display("FAIL change_shadow: got %0d,%0d expected 4,6", r2, r3);
      end
   endtask

   task automatic test_drain();
      logic [15:0] pv, tv, rv;
      apply_reset();
      div_ratio_in = 8'd8;
      clk_en_in    = 1'b1;
      pv = '0; tv = '0; rv = '0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (i == 1) clk_en_in = 1'b0;
         pv = {pv[14:0], sp};
         tv = {tv[14:0], st};
         rv = {rv[14:0], sr};
      end
      n_tests++;
      if (pv !== 16'b111100000000) begin
         n_fail++; $display("FAIL drain_clk: got %b expected %b", pv, 16'b111100000000);
      end
      n_tests++;
      if (tv !== 16'b100000000000) begin
         n_fail++; $display("FAIL drain_tick: got %b expected %b", tv, 16'b100000000000);
      end
      n_tests++;
      if (rv !== 16'b111111100000) begin
         n_fail++; $display("FAIL drain_running: got %b expected %b", rv, 16'b111111100000);
      end
   endtask

   task automatic test_bypass();
      logic [15:0] pv, nv, tv, p0v;
      apply_reset();
      div_ratio_in = 8'd1;
      clk_en_in    = 1'b1;
      pv = '0; nv = '0; tv = '0; p0v = '0;
      for (int i = 0; i < 13; i++) begin
         cyc();
         if (i == 5) div_ratio_in = 8'd3;
         pv  = {pv[14:0], sp};
         nv  = {nv[14:0], sn};
         tv  = {tv[14:0], st};
         p0v = {p0v[14:0], sp0};
      end
      n_tests++;
      if (pv !== 16'b0111111010010) begin
         n_fail++; $display("FAIL byp_to_n3_pos: got %b expected %b", pv, 16'b0111111010010);
      end
      n_tests++;
      if (nv !== 16'b0000000110110) begin
         n_fail++; $display("FAIL byp_to_n3_neg: got %b expected %b", nv, 16'b0000000110110);
      end
      n_tests++;
      if (tv !== 16'b1111111100100) begin
         n_fail++; $display("FAIL byp_to_n3_tick: got %b expected %b", tv, 16'b1111111100100);
      end
      n_tests++;
      if (p0v !== 16'b0111111110110) begin
         n_fail++;
         $display("FAIL byp_to_n3_odd50_off: got %b expected %b", p0v, 16'b0111111110110);
      end
   endtask

   task automatic test_bypass_stop();
      logic [15:0] pv, nv, tv, rv;
      apply_reset();
      div_ratio_in = 8'd0;
      clk_en_in    = 1'b1;
      pv = '0; nv = '0; tv = '0; rv = '0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 2) clk_en_in = 1'b0;
         pv = {pv[14:0], sp};
         nv = {nv[14:0], sn};
         tv = {tv[14:0], st};
         rv = {rv[14:0], sr};
      end
      n_tests++;
      if (pv !== 16'b011100 || nv !== 16'b000000) begin
         n_fail++;
         $display("FAIL byp_stop_clk: got %b/%b expected %b/%b", pv, nv, 16'b011100, 16'b0);
      end
      n_tests++;
      if (tv !== 16'b111000 || rv !== 16'b111000) begin
         n_fail++;
         $display("FAIL byp_stop_tick_running: got %b/%b expected %b", tv, rv, 16'b111000);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] pv, tv;
      logic        all_run;
      apply_reset();
      div_ratio_in = 8'd6;
      clk_en_in    = 1'b1;
      cyc();
      n_tests++;
      if (sp !== 1'b1) begin
         n_fail++; $display("FAIL n6_first_high: got %b expected 1", sp);
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({div_clk_out, div_tick_out, running_out, ratio_active_out, div_clk0} !== 12'd0) begin
         n_fail++;
         $display("FAIL midreset_immediate: got %b expected %b",
                  {div_clk_out, div_tick_out, running_out, ratio_active_out, div_clk0}, 12'd0);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_tests++;
         if ({sp, sn, st, sr} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_hold: got %b expected %b", {sp, sn, st, sr}, 4'b0);
         end
      end
      reset_n = 1'b1;
      pv = '0; tv = '0; all_run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         pv = {pv[14:0], sp};
         tv = {tv[14:0], st};
         all_run = all_run & sr;
      end
      n_tests++;
      if (pv !== 16'b1110001 || tv !== 16'b1000001 || all_run !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_restart: got %b/%b/%b expected %b/%b/1",
                  pv, tv, all_run, 16'b1110001, 16'b1000001);
      end
   endtask

   task automatic test_max_ratio();
      int first, second, hi, hi0;
      apply_reset();
      div_ratio_in = 8'd255;
      clk_en_in    = 1'b1;
      first = -1; second = -1; hi = 0; hi0 = 0;
      for (int i = 0; i < 600 && second < 0; i++) begin
         cyc();
         if (st) begin
            if (first < 0) first = i;
            else second = i;
         end
         if (first >= 0 && second < 0) begin
            hi  += int'(sp) + int'(sn);
            hi0 += int'(sp0) + int'(sn0);
         end
      end
      n_tests++;
      if (first != 0 || second != 255) begin
         n_fail++; $display("FAIL n255_period: got ticks at %0d,%0d expected 0,255", first, second);
      end
      n_tests++;
      if (hi != 255 || hi0 != 256) begin
         n_fail++;
         $display("FAIL n255_high_halves: got %0d/%0d expected 255/256", hi, hi0);
      end
      n_tests++;
      if (ratio_active_out !== 8'd255) begin
         n_fail++; $display("FAIL n255_ratio: got %0d expected 255", ratio_active_out);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_even_ratio();
      test_min_ratio();
      test_odd_ratio();
      test_ratio_change();
      test_drain();
      test_bypass();
      test_bypass_stop();
      test_reset_mid();
      test_max_ratio();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
